// File: rtl/bitstream_pkg.sv
// bitstream_pkg: constants and state encoding shared by the frame transmitter
// and the receive-side preamble detector, so both ends agree on the pattern.
package bitstream_pkg;

    localparam logic [31:0] PREAMBLE     = 32'h5555_5555;
    localparam int          PREAMBLE_LEN = 32;

    // PAR is only reachable when the parity option is compiled in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/bitstream_frame_tx_bit_tick_gen.sv
// bit_tick_gen: bit-period divider. Counts 0..BIT_DIV-1 and wraps; clr parks
// the counter at 0. tick marks the last cycle of a bit, stb the first.
module bit_tick_gen #(
    parameter int BIT_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic stb
);

    localparam int             CW   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(BIT_DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter: held at 0 while cleared, wraps after the last cycle of a bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);
    assign stb  = (cnt == '0);

endmodule

// File: rtl/bitstream_frame_tx.sv
// bitstream_frame_tx: bit-serial frame transmitter. A frame is a 32-bit
// alternating preamble followed by FRAME_BYTES payload bytes, LSB first.
// Optional feature macro: BITSTREAM_TX_PARITY_EN appends one even-parity bit
// after every payload byte (PAR state) and moves the byte-load points to the
// end of that bit.
//
// state | meaning
// IDLE  | line low, divider parked; din_valid_i starts a frame
// PRE   | sending preamble bits 0..31
// DATA  | sending shift[0], shifting right once per bit
// PAR   | sending the parity bit of the current byte (option only)
module bitstream_frame_tx
    import bitstream_pkg::*;
#(
    parameter int BIT_DIV     = 1,
    parameter int FRAME_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din_i,
    input  logic       din_valid_i,
    output logic       din_ready_o,
    output logic       data_o,
    output logic       bit_stb_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       underrun_o
);

    localparam logic [4:0] PRE_LAST  = 5'(PREAMBLE_LEN - 1);
    localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

    tx_state_t  state, state_nx;
    logic [4:0] bit_idx, bit_idx_nx;
    logic [7:0] byte_idx, byte_idx_nx;
    logic [7:0] shift, shift_nx;
    logic       data_nx, stb_nx, done_nx, under_nx;
    logic       tick, stb, clr;
    logic       last_pre, byte_end, load_pt;
`ifdef BITSTREAM_TX_PARITY_EN
    logic       par_bit, par_nx;
`endif

    assign clr = (state == IDLE);

    bit_tick_gen #(
        .BIT_DIV(BIT_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick),
        .stb (stb)
    );

    assign last_pre = (state == PRE) && (bit_idx == PRE_LAST);
`ifdef BITSTREAM_TX_PARITY_EN
    assign byte_end = (state == PAR);
`else
    assign byte_end = (state == DATA) && (bit_idx == 5'd7);
`endif
    // Load points fall on the last cycle of the preamble and of every byte but
    // the final one; this is a pure state decode so din_valid_i never feeds it.
    assign load_pt     = tick && (last_pre || (byte_end && (byte_idx != LAST_BYTE)));
    assign din_ready_o = load_pt;

    // Next-state, counter and output decode.
    always_comb begin
        state_nx    = state;
        bit_idx_nx  = bit_idx;
        byte_idx_nx = byte_idx;
        shift_nx    = shift;
        done_nx     = 1'b0;
        under_nx    = 1'b0;
`ifdef BITSTREAM_TX_PARITY_EN
        par_nx      = par_bit;
`endif
        if (load_pt) begin
            if (din_valid_i) begin
                state_nx    = DATA;
                shift_nx    = din_i;
                bit_idx_nx  = 5'd0;
                byte_idx_nx = last_pre ? 8'd0 : byte_idx + 8'd1;
`ifdef BITSTREAM_TX_PARITY_EN
                par_nx      = ^din_i;
`endif
            end else begin
                state_nx = IDLE;
                under_nx = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    // Only start from a parked divider so bit 0 gets a full period.
                    if (din_valid_i && stb) begin
                        state_nx    = PRE;
                        bit_idx_nx  = 5'd0;
                        byte_idx_nx = 8'd0;
                    end
                end
                PRE: begin
                    if (tick) begin
                        bit_idx_nx = bit_idx + 5'd1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 5'd7) begin
`ifdef BITSTREAM_TX_PARITY_EN
                            state_nx = PAR;
`else
                            // Not a load point here, so this was the final byte.
                            state_nx = IDLE;
                            done_nx  = 1'b1;
`endif
                        end else begin
                            bit_idx_nx = bit_idx + 5'd1;
                            shift_nx   = shift >> 1;
                        end
                    end
                end
`ifdef BITSTREAM_TX_PARITY_EN
                PAR: begin
                    if (tick) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
`endif
                default: state_nx = IDLE;
            endcase
        end

        case (state_nx)
            PRE:     data_nx = PREAMBLE[bit_idx_nx];
            DATA:    data_nx = shift_nx[0];
`ifdef BITSTREAM_TX_PARITY_EN
            PAR:     data_nx = par_nx;
`endif
            default: data_nx = 1'b0;
        endcase

        // The divider reads 0 next cycle when it is cleared now or wraps now.
        stb_nx = (state_nx != IDLE) && (clr || tick);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_idx    <= 5'd0;
            byte_idx   <= 8'd0;
            shift      <= 8'd0;
            data_o     <= 1'b0;
            bit_stb_o  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_idx    <= bit_idx_nx;
            byte_idx   <= byte_idx_nx;
            shift      <= shift_nx;
            data_o     <= data_nx;
            bit_stb_o  <= stb_nx;
            busy_o     <= (state_nx != IDLE);
            done_o     <= done_nx;
            underrun_o <= under_nx;
        end
    end

`ifdef BITSTREAM_TX_PARITY_EN
    // Parity of the loaded byte, captured whole since the shifter loses bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else begin
            par_bit <= par_nx;
        end
    end
`endif

endmodule

// File: tb/tb_bitstream_frame_tx.sv
// tb_bitstream_frame_tx: scoreboard bench for bitstream_frame_tx. Two
// instances (BIT_DIV=1 and BIT_DIV=4, FRAME_BYTES=2). Stimulus pushes the
// expected bits and event cycles; negedge monitors pop and compare.
module tb_bitstream_frame_tx;

`ifdef BITSTREAM_TX_PARITY_EN
    localparam int BPB = 9;
`else
    localparam int BPB = 8;
`endif

    typedef struct {
        logic b;
        int   c;
    } exp_bit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] a_din, b_din;
    logic       a_valid, b_valid;
    logic       a_ready, a_data, a_stb, a_busy, a_done, a_und;
    logic       b_ready, b_data, b_stb, b_busy, b_done, b_und;
    logic       b_last;

    exp_bit_t a_bq[$];
    exp_bit_t b_bq[$];
    int       a_rq[$], b_rq[$], a_dq[$], b_dq[$], a_uq[$], b_uq[$];
    exp_bit_t ea, eb;

    bitstream_frame_tx #(.BIT_DIV(1), .FRAME_BYTES(2)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .din_i      (a_din),
        .din_valid_i(a_valid),
        .din_ready_o(a_ready),
        .data_o     (a_data),
        .bit_stb_o  (a_stb),
        .busy_o     (a_busy),
        .done_o     (a_done),
        .underrun_o (a_und)
    );

    bitstream_frame_tx #(.BIT_DIV(4), .FRAME_BYTES(2)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .din_i      (b_din),
        .din_valid_i(b_valid),
        .din_ready_o(b_ready),
        .data_o     (b_data),
        .bit_stb_o  (b_stb),
        .busy_o     (b_busy),
        .done_o     (b_done),
        .underrun_o (b_und)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_bit(input int inst, input logic b, input int c);
        exp_bit_t e;
        e.b = b;
        e.c = c;
        if (inst == 0) a_bq.push_back(e);
        else           b_bq.push_back(e);
    endfunction

    // kind: 0 ready, 1 done, 2 underrun
    function automatic void push_evt(input int inst, input int kind, input int c);
        if (inst == 0) begin
            if (kind == 0)      a_rq.push_back(c);
            else if (kind == 1) a_dq.push_back(c);
            else                a_uq.push_back(c);
        end else begin
            if (kind == 0)      b_rq.push_back(c);
            else if (kind == 1) b_dq.push_back(c);
            else                b_uq.push_back(c);
        end
    endfunction

    // Expected frame: alternating preamble starting with 1, then bytes LSB
    // first (plus even parity when enabled); bit n appears at t+1+n*d.
    function automatic void push_frame(input int inst, input int t, input int d,
                                       input logic [7:0] b0, input logic [7:0] b1,
                                       input bit underrun);
        int n = 0;
        logic [7:0] by;
        for (int k = 0; k < 32; k++) begin
            push_bit(inst, (k % 2 == 0) ? 1'b1 : 1'b0, t + 1 + n * d);
            n++;
        end
        for (int j = 0; j < (underrun ? 1 : 2); j++) begin
            by = (j == 0) ? b0 : b1;
            for (int i = 0; i < 8; i++) begin
                push_bit(inst, by[i], t + 1 + n * d);
                n++;
            end
            if (BPB == 9) begin
                push_bit(inst, ^by, t + 1 + n * d);
                n++;
            end
        end
        push_evt(inst, 0, t + 32 * d);
        push_evt(inst, 0, t + (32 + BPB) * d);
        if (underrun) push_evt(inst, 2, t + (32 + BPB) * d + 1);
        else          push_evt(inst, 1, t + (32 + 2 * BPB) * d + 1);
    endfunction

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int inst, input logic v, input logic [7:0] b);
        if (inst == 0) begin
            a_valid = v;
            a_din   = b;
        end else begin
            b_valid = v;
            b_din   = b;
        end
    endtask

    // Starts a frame in the current cycle and feeds the second byte after
    // the first load point (or drops valid for an underrun).
    task automatic send_frame(input int inst, input logic [7:0] b0, input logic [7:0] b1,
                              input bit underrun, input logic keep_valid,
                              input logic [7:0] next_din);
        int t, d;
        t = cyc;
        d = (inst == 0) ? 1 : 4;
        drive(inst, 1'b1, b0);
        push_frame(inst, t, d, b0, b1, underrun);
        wait_until(t + 32 * d + 1);
        drive(inst, underrun ? 1'b0 : 1'b1, b1);
        wait_until(t + (32 + BPB) * d + 1);
        drive(inst, keep_valid, next_din);
    endtask

    // Monitor for the BIT_DIV=1 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_stb) begin
                check_eq("a_bit_avail", int'(a_bq.size() > 0), 1);
                if (a_bq.size() > 0) begin
                    ea = a_bq.pop_front();
                    check_eq("a_bit_value", a_data, ea.b);
                    check_eq("a_bit_cycle", cyc, ea.c);
                end
            end
            if (!a_busy) check_eq("a_idle_data", a_data, 0);
            if (a_ready) begin
                check_eq("a_ready_avail", int'(a_rq.size() > 0), 1);
                if (a_rq.size() > 0) check_eq("a_ready_cycle", cyc, a_rq.pop_front());
            end
            if (a_done) begin
                check_eq("a_done_avail", int'(a_dq.size() > 0), 1);
                if (a_dq.size() > 0) check_eq("a_done_cycle", cyc, a_dq.pop_front());
            end
            if (a_und) begin
                check_eq("a_und_avail", int'(a_uq.size() > 0), 1);
                if (a_uq.size() > 0) check_eq("a_und_cycle", cyc, a_uq.pop_front());
                check_eq("a_und_busy", a_busy, 0);
                check_eq("a_und_data", a_data, 0);
            end
        end
    end

    // Monitor for the BIT_DIV=4 instance, including bit hold between strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (b_stb) begin
                check_eq("b_bit_avail", int'(b_bq.size() > 0), 1);
                if (b_bq.size() > 0) begin
                    eb = b_bq.pop_front();
                    check_eq("b_bit_value", b_data, eb.b);
                    check_eq("b_bit_cycle", cyc, eb.c);
                end
                b_last = b_data;
            end else if (b_busy) begin
                check_eq("b_bit_hold", b_data, b_last);
            end
            if (!b_busy) check_eq("b_idle_data", b_data, 0);
            if (b_ready) begin
                check_eq("b_ready_avail", int'(b_rq.size() > 0), 1);
                if (b_rq.size() > 0) check_eq("b_ready_cycle", cyc, b_rq.pop_front());
            end
            if (b_done) begin
                check_eq("b_done_avail", int'(b_dq.size() > 0), 1);
                if (b_dq.size() > 0) check_eq("b_done_cycle", cyc, b_dq.pop_front());
            end
            if (b_und) begin
                check_eq("b_und_avail", int'(b_uq.size() > 0), 1);
                if (b_uq.size() > 0) check_eq("b_und_cycle", cyc, b_uq.pop_front());
                check_eq("b_und_busy", b_busy, 0);
            end
        end
    end

    initial begin
        int t, t1;
        a_din   = 8'h00;
        b_din   = 8'h00;
        a_valid = 1'b0;
        b_valid = 1'b0;
        b_last  = 1'b0;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state of both instances.
        check_eq("rst_a_data",  a_data,  0);
        check_eq("rst_a_stb",   a_stb,   0);
        check_eq("rst_a_busy",  a_busy,  0);
        check_eq("rst_a_ready", a_ready, 0);
        check_eq("rst_a_done",  a_done,  0);
        check_eq("rst_a_und",   a_und,   0);
        check_eq("rst_b_data",  b_data,  0);
        check_eq("rst_b_stb",   b_stb,   0);
        check_eq("rst_b_busy",  b_busy,  0);
        check_eq("rst_b_ready", b_ready, 0);
        check_eq("rst_b_done",  b_done,  0);
        check_eq("rst_b_und",   b_und,   0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // A5,3C at BIT_DIV=1: done at T+49 without parity.
        send_frame(0, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'h00);
        wait_until(cyc + BPB + 6);

        // Same bytes at BIT_DIV=4: ready at T+128/T+160, done at T+193 without parity.
        send_frame(1, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'h00);
        wait_until(cyc + BPB * 4 + 6);

        // Underrun: valid dropped before the second load point.
        send_frame(0, 8'h5A, 8'h00, 1'b1, 1'b0, 8'h00);
        wait_until(cyc + 8);

        // Byte 07 (parity 1 when enabled), then E1.
        send_frame(0, 8'h07, 8'hE1, 1'b0, 1'b0, 8'h00);
        wait_until(cyc + BPB + 6);

        // Reset in the middle of DATA on the BIT_DIV=4 instance.
        t = cyc;
        drive(1, 1'b1, 8'h81);
        push_frame(1, t, 4, 8'h81, 8'h42, 1'b0);
        wait_until(t + 129);
        drive(1, 1'b1, 8'h42);
        wait_until(t + 130);
        #2;
        check_eq("mid_data_before_rst", b_data, 1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_b_data",  b_data,  0);
        check_eq("async_rst_b_busy",  b_busy,  0);
        check_eq("async_rst_b_stb",   b_stb,   0);
        check_eq("async_rst_b_ready", b_ready, 0);
        check_eq("async_rst_b_done",  b_done,  0);
        check_eq("async_rst_b_und",   b_und,   0);
        b_bq.delete();
        b_rq.delete();
        b_dq.delete();
        b_uq.delete();
        drive(1, 1'b1, 8'h81);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(1, 8'h81, 8'h42, 1'b0, 1'b0, 8'h00);
        wait_until(cyc + BPB * 4 + 6);

        // Back-to-back frames with valid held high across done_o.
        t1 = cyc;
        send_frame(0, 8'hC3, 8'h96, 1'b0, 1'b1, 8'h5A);
        wait_until(t1 + 32 + 2 * BPB + 1);
        send_frame(0, 8'h5A, 8'hF0, 1'b0, 1'b0, 8'h00);
        wait_until(cyc + BPB + 10);

        // Nothing expected may be left unseen.
        check_eq("a_bits_left",  a_bq.size(), 0);
        check_eq("a_ready_left", a_rq.size(), 0);
        check_eq("a_done_left",  a_dq.size(), 0);
        check_eq("a_und_left",   a_uq.size(), 0);
        check_eq("b_bits_left",  b_bq.size(), 0);
        check_eq("b_ready_left", b_rq.size(), 0);
        check_eq("b_done_left",  b_dq.size(), 0);
        check_eq("b_und_left",   b_uq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitstream_frame_tx.md
# bitstream_frame_tx

Serial frame transmitter for the FM-demodulator data path: it takes payload bytes over a valid/ready handshake and emits one bit-serial frame. Each frame is a 32-bit alternating preamble, then FRAME_BYTES payload bytes sent LSB first. It is the transmit-side counterpart of the preamble detector in Merge_Data; with BIT_DIV=1, data_o drives the detector input directly.

## Interface
- BIT_DIV, default 1: clock cycles per transmitted bit, range 1..65535.
- FRAME_BYTES, default 4: payload bytes per frame, range 1..255.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- din_i  in  8  payload byte.
- din_valid_i  in  1  payload byte available.
  - In IDLE, this input also requests a new frame.
- din_ready_o  out  1  byte-load point; a byte transfers when din_valid_i && din_ready_o.
- data_o  out  1  serial bit output.
- bit_stb_o  out  1  one-cycle pulse in the first cycle of every transmitted bit.
- busy_o  out  1  high while a frame is in progress (any state other than IDLE).
- done_o  out  1  one-cycle pulse when a frame completes normally.
- underrun_o  out  1  one-cycle pulse when a frame aborts for lack of data.

## Operation
- States: IDLE, PRE, DATA, PAR. PAR exists only with the Configuration macro defined.
- IDLE:
  - data_o=0, busy_o=0; the bit-divider counter is held at 0.
  - din_valid_i=1 moves to PRE; the byte is not consumed yet.
- PRE: sends 32 bits; bit k = PREAMBLE[k], with PREAMBLE=32'h5555_5555. The line therefore carries 1,0,1,0,… starting with 1.
- Byte-load points:
  - Last cycle of the final preamble bit.
  - Last cycle of the final bit (data or parity) of every byte except the last.
  - din_ready_o=1 only at these points. It is Moore-decoded from state and counters and is independent of din_valid_i.
- Transfer at a load point: din_i is latched into an 8-bit shift register and the block enters DATA.
- No transfer at a load point: underrun_o pulses on the next cycle, the state returns to IDLE, and data_o=0.
- DATA: sends shift[0] first and shifts right once per bit; 8 bits per byte; byte counter 0..FRAME_BYTES-1.
- After the last bit of byte FRAME_BYTES-1 (including its parity bit when enabled): return to IDLE; done_o pulses on the first IDLE cycle.
- Bit divider: counts 0..BIT_DIV-1 while busy. A bit boundary occurs when the counter wraps. bit_stb_o asserts when the counter equals 0 in any state other than IDLE.
- Back-to-back frames: a new frame may start on the first IDLE cycle, i.e. the cycle done_o is high, if din_valid_i=1.

## Timing
- Reset values: data_o=0, bit_stb_o=0, busy_o=0, din_ready_o=0, done_o=0, underrun_o=0; state IDLE; all counters 0.
- Reset is asynchronous. Asserting it mid-frame aborts immediately, with no done_o or underrun_o pulse.
- All outputs are registered except din_ready_o.
- Frame start: din_valid_i sampled high in IDLE at cycle T.
  - Preamble bit 0 appears at T+1 with bit_stb_o=1.
  - Preamble bit k occupies cycles T+1+k·BIT_DIV through T+(k+1)·BIT_DIV.
- First load point: cycle T+32·BIT_DIV. Payload bit 0 appears at T+32·BIT_DIV+1.
- Frame length: (32 + FRAME_BYTES·B)·BIT_DIV cycles, where B=8, or B=9 with parity enabled.
- done_o pulses on the cycle after the last frame cycle.
- din_valid_i going low in the middle of a byte is ignored; it is sampled only at load points.

## Configuration
- BITSTREAM_TX_PARITY_EN defined:
  - PAR state present; one even-parity bit (XOR of the 8 data bits) is sent after each byte.
  - Load points move to the end of each parity bit; B=9.
- Not defined:
  - No parity bit; B=8; DATA goes straight to the next byte or to IDLE.

## Structure
- Package bitstream_pkg holds:
  - PREAMBLE (32'h5555_5555) and PREAMBLE_LEN (32).
  - The state enum {IDLE, PRE, DATA, PAR}.
  - Shared with the receive side so both ends use the same pattern constant.
- One sub-module, bit_tick_gen: the BIT_DIV counter with a clear input. Outputs are the tick (counter at BIT_DIV-1) and the strobe (counter at 0).

## Test plan
- BIT_DIV=1, FRAME_BYTES=2, bytes A5,3C held valid, no parity. Required response:
  - data_o = 1,0 repeated 16 times, then 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0.
  - done_o pulses at T+49.
  - A detector driven from data_o asserts start after bit 31.
- Same configuration with BIT_DIV=4:
  - bit_stb_o pulses every 4 cycles; each bit is held 4 cycles.
  - din_ready_o high only at T+128 and T+160; done_o at T+193.
- Underrun: din_valid_i dropped before the second load point.
  - underrun_o pulses once; busy_o=0 on that cycle; data_o=0; no done_o.
- Parity enabled, byte 07:
  - Sequence 1,1,1,0,0,0,0,0 followed by parity 1; frame length (32+9·FRAME_BYTES)·BIT_DIV.
- rst asserted during DATA:
  - All outputs are 0 asynchronously.
  - After release with din_valid_i=1, a full preamble restarts from bit 0.
- Back-to-back frames, din_valid_i held high:
  - The second preamble bit 0 appears on the cycle after done_o, with no idle gap beyond that cycle.
